// File: rtl/board_pkg.sv
// Board-level constants shared by the ULX3S glue logic: clock rate, button
// count and which buttons are wired active-low, plus a helper to turn a
// millisecond duration into a clock-cycle count.
package board_pkg;

    localparam int CLK_HZ = 25_000_000;

    localparam int N_BTN = 7;

    // btn[0] (PWR) pulls the pin low when pressed; the rest pull it high.
    localparam logic [N_BTN-1:0] BTN_ACTIVE_LOW = 7'b0000001;

    // Debounce window used by default: 10 ms of clock cycles.
    localparam int DB_MS = 10;

    // Cycles of CLK_HZ in the given number of milliseconds.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: polarity normalisation, 2-FF synchroniser, hold-time
// counter and the accepted ("stable") level with registered press/release
// pulses. A new level is only accepted after it has been seen unchanged in
// the synchronised domain for DB_CYCLES consecutive cycles; any return to
// the accepted level throws away all progress.
module btn_debounce_chan
    import board_pkg::*;
#(
    parameter int DB_CYCLES  = 250000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release
);

    // Counter only needs to reach DB_CYCLES-1; guard the degenerate width.
    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // STABLE: synchronised input agrees with accepted level.
    // PENDING: it disagrees and the hold counter is running.
    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic             raw;
    logic             s1;
    logic             s2;
    logic             stb;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic             expire;

    // Flip active-low pins so that 1 always means "pressed" from here on.
    assign raw = i_btn ^ ACTIVE_LOW;

    assign state  = (s2 != stb) ? ST_PENDING : ST_STABLE;
    assign expire = (state == ST_PENDING) && (cnt == CNT_MAX);

    // Two-flop synchroniser for the asynchronous pin; reset means "not pressed".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Hold counter: runs only while pending, cleared on acceptance or on any bounce back.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_STABLE: begin
                    cnt <= '0;
                end
                ST_PENDING: begin
                    if (cnt == CNT_MAX) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    // Accepted level plus one-cycle edge pulses, all updated on the accept edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stb       <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_press   <= expire &  s2;
            o_release <= expire & ~s2;
            if (expire) begin
                stb <= s2;
            end
        end
    end

    assign o_btn = stb;

endmodule

// File: rtl/btn_debounce.sv
// Button conditioning for the ULX3S: one independent debounce channel per
// button pin. Downstream logic uses o_btn (1 = pressed) instead of raw btn,
// and o_press/o_release for single-cycle edge events.
module btn_debounce
    import board_pkg::*;
#(
    parameter int                        N_BTN      = board_pkg::N_BTN,
    parameter int                        DB_CYCLES  = board_pkg::ms_to_cycles(board_pkg::DB_MS),
    parameter logic [board_pkg::N_BTN-1:0] ACTIVE_LOW = board_pkg::BTN_ACTIVE_LOW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_btn,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        btn_debounce_chan #(
            .DB_CYCLES  (DB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW[g])
        ) u_chan (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_btn     (i_btn[g]),
            .o_btn     (o_btn[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with a 16-cycle debounce window. Stimulus pushes
// the pulses it expects (channel, kind, exact cycle) into a scoreboard; a
// monitor pops and compares whenever a press/release pulse appears.
// Inputs change on the falling edge, so a change lands in s1 at the next
// rising edge E0 and the pulse appears at E0+17, i.e. 18 rising edges after
// the cycle count seen when the stimulus was applied.
module tb_btn_debounce;

   localparam int DB  = 16;
   localparam int LAT = DB + 2;

   typedef struct {
      int ch;
      bit press;
      int at;
   } ev_t;

   logic       i_clk;
   logic       i_rst_n;
   logic [6:0] i_btn;
   logic [6:0] o_btn;
   logic [6:0] o_press;
   logic [6:0] o_release;

   int   cyc;
   int   checks;
   int   errors;
   ev_t  sb[$];
   logic [6:0] cur;

   btn_debounce #(
      .N_BTN      (7),
      .DB_CYCLES  (DB),
      .ACTIVE_LOW (7'b0000001)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_btn     (i_btn),
      .o_btn     (o_btn),
      .o_press   (o_press),
      .o_release (o_release)
   );

   // 100 MHz-ish bench clock; only the cycle count matters.
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Rising-edge counter used to timestamp expected and observed pulses.
   always @(posedge i_clk) begin
      cyc <= cyc + 1;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic applyStimulus(input logic [6:0] btn, input int hold);
      cur   = btn;
      i_btn = btn;
      waitCycles(hold);
   endtask

   task automatic expectPulse(input int ch, input bit press, input int lat);
      ev_t e;
      e.ch    = ch;
      e.press = press;
      e.at    = cyc + lat;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
      end
   endtask

   // Monitor: every pulse seen on the falling edge must match the scoreboard head.
   initial begin
      ev_t e;
      forever begin
         @(negedge i_clk);
         for (int ch = 0; ch < 7; ch++) begin
            if (o_press[ch] && o_release[ch]) begin
               checks++;
               errors++;
               $display("[TB] FAIL both_pulses_ch%0d: press and release high together at cycle %0d, required at most one", ch, cyc);
            end else if (o_press[ch] || o_release[ch]) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL unexpected_pulse_ch%0d: got %s at cycle %0d, required no pulse",
                           ch, o_press[ch] ? "press" : "release", cyc);
               end else begin
                  e = sb.pop_front();
                  if (e.ch != ch || e.press != o_press[ch] || e.at != cyc) begin
                     errors++;
                     $display("[TB] FAIL pulse_ch%0d: got ch%0d %s at cycle %0d, required ch%0d %s at cycle %0d",
                              ch, ch, o_press[ch] ? "press" : "release", cyc,
                              e.ch, e.press ? "press" : "release", e.at);
                  end
               end
            end
         end
      end
   end

   // Hard time limit so a stuck run still reports.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no end of stimulus, required finish within 200000 time units");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus sequence.
   initial begin
      cyc     = 0;
      checks  = 0;
      errors  = 0;
      i_rst_n = 1'b0;
      cur     = 7'b0000001;
      i_btn   = cur;

      // Reset with every button idle (btn[0] idle is high).
      waitCycles(4);
      checkOutput("reset_o_btn",     o_btn,     7'b0);
      checkOutput("reset_o_press",   o_press,   7'b0);
      checkOutput("reset_o_release", o_release, 7'b0);
      i_rst_n = 1'b1;
      waitCycles(40);
      checkOutput("idle_o_btn", o_btn, 7'b0);

      // Clean press and release on channel 2.
      expectPulse(2, 1'b1, LAT);
      applyStimulus(cur | 7'b0000100, 30);
      checkOutput("press2_o_btn", o_btn, 7'b0000100);
      expectPulse(2, 1'b0, LAT);
      applyStimulus(cur & ~7'b0000100, 30);
      checkOutput("release2_o_btn", o_btn, 7'b0);

      // Bounce on channel 3: 5 high / 3 low never survives the window.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(cur | 7'b0001000, 5);
         applyStimulus(cur & ~7'b0001000, 3);
      end
      checkOutput("bounce3_o_btn", o_btn, 7'b0);
      expectPulse(3, 1'b1, LAT);
      applyStimulus(cur | 7'b0001000, 30);
      checkOutput("settle3_o_btn", o_btn, 7'b0001000);
      expectPulse(3, 1'b0, LAT);
      applyStimulus(cur & ~7'b0001000, 30);

      // Glitch on channel 4: 15 cycles rejected, then a long press accepted.
      applyStimulus(cur | 7'b0010000, 15);
      applyStimulus(cur & ~7'b0010000, 30);
      checkOutput("glitch4_o_btn", o_btn, 7'b0);
      expectPulse(4, 1'b1, LAT);
      applyStimulus(cur | 7'b0010000, 30);
      checkOutput("hold4_o_btn", o_btn, 7'b0010000);
      expectPulse(4, 1'b0, LAT);
      applyStimulus(cur & ~7'b0010000, 30);

      // Active-low channel 0: pin falling means pressed.
      expectPulse(0, 1'b1, LAT);
      applyStimulus(cur & ~7'b0000001, 30);
      checkOutput("polarity0_o_btn", o_btn, 7'b0000001);
      expectPulse(0, 1'b0, LAT);
      applyStimulus(cur | 7'b0000001, 30);
      checkOutput("polarity0_rel_o_btn", o_btn, 7'b0);

      // Channels 1..5 pressed together, reset mid-count, then all accepted together.
      applyStimulus(cur | 7'b0111110, 10);
      i_rst_n = 1'b0;
      #1;
      checkOutput("midreset_o_btn",     o_btn,     7'b0);
      checkOutput("midreset_o_press",   o_press,   7'b0);
      checkOutput("midreset_o_release", o_release, 7'b0);
      waitCycles(3);
      i_rst_n = 1'b1;
      for (int ch = 1; ch <= 5; ch++) expectPulse(ch, 1'b1, LAT);
      waitCycles(30);
      checkOutput("simul_o_btn", o_btn, 7'b0111110);
      for (int ch = 1; ch <= 5; ch++) expectPulse(ch, 1'b0, LAT);
      applyStimulus(cur & ~7'b0111110, 30);
      checkOutput("final_o_btn", o_btn, 7'b0);

      // Every expected pulse must have been consumed.
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d pulses never seen, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
